rtc_digit_latch: RTL

- Upstream stage of the on-screen text generator: holds the BCD digits (date, time, timer) that the generator renders as characters {3'b011, digit}.
- Accepts byte writes from the RTC read/control path into a shadow bank, range-checks them, and commits the shadow bank to the display bank only at frame start (vertical blanking), so a frame never shows a half-updated value.
- Optional cursor blink marks the field being edited.

---
 rtl/rtc_digit_latch.sv | 113 +++++++++++
 1 files changed

// File: rtl/rtc_digit_latch.sv
// BCD digit latch for the on-screen text generator: range-checked shadow bank committed to the
// display bank at frame start. Optional cursor blink under `define CURSOR_BLINK_EN.
module rtc_digit_latch #(
  parameter int unsigned NUM_REGS     = 9,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  frame_start,
  input  logic                  err_clr,
  input  logic [3:0]            edit_sel,
  output logic [8*NUM_REGS-1:0] digits,
  output logic                  commit,
  output logic                  pending,
  output logic                  err_sticky,
  output logic [NUM_REGS-1:0]   blank_mask
);

  // Day and month reset to 01, everything else to 00.
  localparam logic [NUM_REGS-1:0][7:0] ResetBank = (8*NUM_REGS)'(16'h0101);

  logic [NUM_REGS-1:0][7:0] shadow_q, display_q;
  logic [NUM_REGS-1:0]      dirty_q, dirty_d;
  logic                     commit_q, err_q;
  logic                     wr_ok, wr_bad, do_commit;

  // Once both nibbles are <= 9, packed BCD compares in the same order as the decimal value.
  function automatic logic wr_valid(input logic [3:0] addr, input logic [7:0] data);
    logic [7:0] max_v;
    logic       nonzero;
    nonzero = 1'b0;
    unique case (addr)
      4'd0:                      begin max_v = 8'h31; nonzero = 1'b1; end
      4'd1:                      begin max_v = 8'h12; nonzero = 1'b1; end
      4'd2:                      max_v = 8'h99;
      4'd3, 4'd6:                max_v = 8'h23;
      4'd4, 4'd5, 4'd7, 4'd8:    max_v = 8'h59;
      default:                   return 1'b0;
    endcase
    return (data[7:4] <= 4'd9) && (data[3:0] <= 4'd9) && (data <= max_v) &&
           !(nonzero && data == 8'h00);
  endfunction

  assign wr_ok     = wr_en && wr_valid(wr_addr, wr_data);
  assign wr_bad    = wr_en && !wr_valid(wr_addr, wr_data);
  assign pending   = |dirty_q;
  assign do_commit = frame_start && pending;

  // A write in the commit cycle survives the clear so it shows on the following frame.
  always_comb begin
    dirty_d = do_commit ? '0 : dirty_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_ok && wr_addr == 4'(i)) dirty_d[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow_q  <= ResetBank;
      display_q <= ResetBank;
      dirty_q   <= '0;
      commit_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      commit_q <= do_commit;
      dirty_q  <= dirty_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (do_commit && dirty_q[i]) display_q[i] <= shadow_q[i];
        if (wr_ok && wr_addr == 4'(i)) shadow_q[i] <= wr_data;
      end
      if (wr_bad) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign digits     = display_q;
  assign commit     = commit_q;
  assign err_sticky = err_q;

`ifdef CURSOR_BLINK_EN
  logic [7:0]          blink_cnt_q;
  logic                phase_q, phase_next, cnt_wrap;
  logic [NUM_REGS-1:0] blank_q;

  assign cnt_wrap   = (blink_cnt_q == 8'(BLINK_FRAMES - 1));
  assign phase_next = cnt_wrap ? ~phase_q : phase_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      blank_q     <= '0;
    end else if (frame_start) begin
      blink_cnt_q <= cnt_wrap ? 8'd0 : blink_cnt_q + 8'd1;
      phase_q     <= phase_next;
      for (int i = 0; i < NUM_REGS; i++) begin
        blank_q[i] <= phase_next && (edit_sel == 4'(i));
      end
    end
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = '0;
`endif

endmodule
